pc_sequencer: RTL and testbench

- Owns the architectural program counter register and sequences instruction fetch for the accumulator processor.
- Drives the PCALU incrementer (PC+2) and selects the next PC from three sources: sequential (PCALU result), branch/jump target, or return-address stack (call/return).
- Handshakes with instruction memory and with the main control unit, which signals instruction completion.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the accumulator processor.
// Picks the next PC from the PC+2 incrementer, a branch target or a circular return-address stack.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic [WIDTH-1:0] pcalu_in,
    input  logic [WIDTH-1:0] pcalu_out,
    input  logic             instr_done,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call,
    input  logic             ret,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [1:0]       state,
    output logic             ras_err
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StFetch  = 2'd1,
        StExec   = 2'd2,
        StHalted = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push;
    logic [WIDTH-1:0] top;

    // sp_q points at the next free slot; a push on a full stack overwrites the oldest entry.
    assign top = ras_q[sp_q - 1'b1];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push    = 1'b0;
        unique case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                if (imem_ack) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (instr_done) begin
                    state_d = halt ? StHalted : StFetch;
                    if (ret) begin
                        if (call) begin
                            err_d = 1'b1;
                        end
                        if (cnt_q != '0) begin
                            pc_d  = {top[WIDTH-1:1], 1'b0};
                            sp_d  = sp_q - 1'b1;
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            pc_d  = pcalu_out;
                            err_d = 1'b1;
                        end
                    end else if (call) begin
                        push = 1'b1;
                        pc_d = {br_target[WIDTH-1:1], 1'b0};
                        sp_d = sp_q + 1'b1;
                        if (cnt_q == CW'(RAS_DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (br_taken) begin
                        pc_d = {br_target[WIDTH-1:1], 1'b0};
                    end else begin
                        pc_d = pcalu_out;
                    end
                end
            end
            StHalted: state_d = StHalted;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            sp_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push) begin
            ras_q[sp_q] <= pcalu_out;
        end
    end

    assign imem_req  = (state_q == StFetch);
    assign imem_addr = pc_q;
    assign pcalu_in  = pc_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instruction streams
// checked against an instruction-level model of PC, return stack and error flag.
module tb_pc_sequencer;

    localparam int unsigned      DEPTH = 4;
    localparam logic [15:0]      RPC   = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] pcalu_in;
    logic [15:0] pcalu_out;
    logic        instr_done = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] pc;
    logic [1:0]  state;
    logic        ras_err;

    int passed = 0;
    int total  = 0;

    // Reference model
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_err;
    int          m_state;

    pc_sequencer #(
        .WIDTH    (16),
        .RESET_PC (RPC),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .pcalu_in  (pcalu_in),
        .pcalu_out (pcalu_out),
        .instr_done(instr_done),
        .br_taken  (br_taken),
        .br_target (br_target),
        .call      (call),
        .ret       (ret),
        .halt      (halt),
        .pc        (pc),
        .state     (state),
        .ras_err   (ras_err)
    );

    assign pcalu_out = pcalu_in + 16'd2;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check({tag, ".addr"}, 32'(imem_addr), 32'(m_pc));
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".req"}, 32'(imem_req), 32'(m_state == 1));
        check({tag, ".err"}, 32'(ras_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_ctrl();
        br_taken  = 1'($urandom);
        call      = 1'($urandom);
        ret       = 1'($urandom);
        halt      = 1'($urandom);
        br_target = 16'($urandom);
    endtask

    task automatic clear_ctrl();
        imem_ack = 0; instr_done = 0; br_taken = 0; call = 0; ret = 0; halt = 0; br_target = '0;
    endtask

    // Called from just after a rising edge; drops reset mid-cycle.
    task automatic do_reset();
        #3;
        clear_ctrl();
        reset_n = 1'b0;
        m_pc = RPC; m_state = 0; m_err = 1'b0; m_stack.delete();
        #1;
        check_all("rst_async");
        tick();
        tick();
        check_all("rst_held");
        reset_n = 1'b1;
        tick();
        m_state = 1;
        check_all("boot_exit");
    endtask

    // Fetch phase: ACK withheld for 'stall' cycles; DONE noise during FETCH must be ignored.
    task automatic do_fetch(input int stall);
        for (int i = 0; i < stall; i++) begin
            imem_ack = 1'b0; instr_done = 1'($urandom); noise_ctrl();
            tick();
            check_all("fetch_stall");
        end
        imem_ack = 1'b1; instr_done = 1'($urandom); noise_ctrl();
        tick();
        m_state = 2;
        check_all("fetch_ack");
    endtask

    task automatic do_exec(input int wait_cyc, input bit b, input bit c, input bit r,
                           input bit h, input logic [15:0] tgt);
        logic [15:0] seq;
        for (int i = 0; i < wait_cyc; i++) begin
            instr_done = 1'b0; imem_ack = 1'($urandom); noise_ctrl();
            tick();
            check_all("exec_wait");
        end
        imem_ack = 1'($urandom); instr_done = 1'b1;
        br_taken = b; call = c; ret = r; halt = h; br_target = tgt;
        seq = m_pc + 16'd2;
        if (r) begin
            if (c) m_err = 1'b1;
            if (m_stack.size() > 0) m_pc = m_stack.pop_back() & 16'hFFFE;
            else begin
                m_pc = seq; m_err = 1'b1;
            end
        end else if (c) begin
            if (m_stack.size() == DEPTH) begin
                void'(m_stack.pop_front()); m_err = 1'b1;
            end
            m_stack.push_back(seq);
            m_pc = tgt & 16'hFFFE;
        end else if (b) begin
            m_pc = tgt & 16'hFFFE;
        end else begin
            m_pc = seq;
        end
        m_state = h ? 3 : 1;
        tick();
        clear_ctrl();
        check_all("exec_done");
    endtask

    task automatic instr(input int stall, input int wait_cyc, input bit b, input bit c,
                         input bit r, input bit h, input logic [15:0] tgt);
        do_fetch(stall);
        do_exec(wait_cyc, b, c, r, h, tgt);
    endtask

    initial begin
        int k;
        // 1. Reset then back-to-back sequential instructions
        do_reset();
        instr(0, 0, 0, 0, 0, 0, 16'h0);
        check("seq_pc_2", 32'(pc), 32'h0002);
        instr(0, 0, 0, 0, 0, 0, 16'h0);
        check("seq_pc_4", 32'(pc), 32'h0004);
        // 2. Fetch stall, then taken branch with odd target
        instr(3, 0, 1, 0, 0, 0, 16'h0041);
        check("branch_pc", 32'(pc), 32'h0040);
        // 3. Nested call/return
        instr(0, 1, 1, 0, 0, 0, 16'h0010);
        instr(0, 0, 0, 1, 0, 0, 16'h0100);
        check("call1", 32'(pc), 32'h0100);
        instr(1, 0, 0, 1, 0, 0, 16'h0200);
        check("call2", 32'(pc), 32'h0200);
        instr(0, 2, 0, 0, 1, 0, 16'h0);
        check("ret1", 32'(pc), 32'h0102);
        instr(0, 0, 0, 0, 1, 0, 16'h0);
        check("ret2", 32'(pc), 32'h0012);
        check("nest_err", 32'(ras_err), 32'h0);
        // 4. Return on empty stack, then overflow
        instr(0, 0, 1, 0, 0, 0, 16'h0020);
        instr(0, 0, 0, 0, 1, 0, 16'h0);
        check("ret_empty_pc", 32'(pc), 32'h0022);
        check("ret_empty_err", 32'(ras_err), 32'h1);
        do_reset();
        for (int i = 0; i < 5; i++) instr(0, 0, 0, 1, 0, 0, 16'(16'h1000 * (i + 1) + 1));
        check("ovf_err", 32'(ras_err), 32'h1);
        for (int i = 0; i < 4; i++) instr(0, 0, 0, 0, 1, 0, 16'h0);
        // Pushes were 0002,1002,2002,3002,4002; LIFO of last four ends at 1002
        check("ovf_last_ret", 32'(pc), 32'h1002);
        // Randomized instruction stream
        do_reset();
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            instr($urandom_range(0, 2), $urandom_range(0, 2),
                  k inside {2, 3, 9}, k inside {4, 5, 8, 9}, k inside {6, 7, 8}, 1'b0,
                  16'($urandom));
        end
        // 5. Wrap-around, then halt
        instr(0, 0, 1, 0, 0, 0, 16'hFFFF);
        check("at_fffe", 32'(pc), 32'hFFFE);
        instr(0, 0, 0, 0, 0, 0, 16'h0);
        check("wrap_pc", 32'(pc), 32'h0000);
        instr(0, 0, 0, 0, 0, 1, 16'h0);
        check("halt_pc", 32'(pc), 32'h0002);
        check("halt_state", 32'(state), 32'h3);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'($urandom); instr_done = 1'($urandom); noise_ctrl();
            tick();
            check_all("halted_hold");
        end
        clear_ctrl();
        // 6. Async reset mid-EXEC with two stacked returns
        do_reset();
        instr(0, 0, 0, 1, 0, 0, 16'h0010);
        instr(0, 0, 0, 1, 0, 0, 16'h0030);
        check("pre_rst_pc", 32'(pc), 32'h0030);
        do_fetch(0);
        do_reset();
        instr(0, 0, 0, 0, 1, 0, 16'h0);
        check("post_rst_ret_pc", 32'(pc), 32'h0002);
        check("post_rst_ret_err", 32'(ras_err), 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
